intr_ctrl: RTL
==============

# intr_ctrl

Memory-mapped interrupt controller that sits between the I/O devices' IRQ outputs (switches, keys, timer) and the processor's interrupt input. It masks the request lines, picks one winner per interrupt with round-robin priority, and presents it to the CPU. It then holds the winner's ID through an acknowledge/end-of-interrupt handshake, so exactly one interrupt is in service at a time. Registers share the same ABUS/DBUS/WE/FLUSH bus as the other devices.

## Interface
- BITS, 32, data/address bus width
- BASE, 32'hF0000800, address of IMASK; IPEND = BASE+4, ICUR/EOI = BASE+8
- NIRQ, 4, number of request lines (1..16)
- CLK  in  1  system clock, all state on posedge
- RESET  in  1  asynchronous, active-high reset
- ABUS  in  BITS  address bus
- DBUS  inout  BITS  data bus; driven only on a read hit, otherwise Z
- WE  in  1  write enable (1 = write, 0 = read)
- FLUSH  in  1  pipeline flush; when 1, no register is selected
- IRQ  in  NIRQ  level-sensitive device requests, bit i = source i
- INTA  in  1  one-cycle CPU acknowledge pulse
- INTR  out  1  interrupt request to CPU
- DEBUG  out  8  {state[1:0], cur_id[3:0], 2'b0}

## Operation
- Select: hit = (ABUS == addr) && !FLUSH; read hit = hit && !WE; write hit = hit && WE.
- IMASK (rw): bits [NIRQ-1:0]; upper bits read 0. Write loads DBUS[NIRQ-1:0].
- IPEND (ro): IRQ & IMASK, combinational. Writes are ignored.
- ICUR (read at BASE+8): {valid at bit 31, zeros, cur_id[3:0]}. valid = state is REQ or SERV. In IDLE, ICUR reads 0.
- EOI (write at BASE+8): data is ignored. Honoured only in SERV.
- FSM states: IDLE, REQ, SERV.
  - IDLE: if IPEND != 0, latch winner into cur_id and go to REQ.
  - REQ: INTR = 1.
    - On INTA, go to SERV.
    - Otherwise, if IPEND[cur_id] == 0 (source dropped or was masked), withdraw: go to IDLE, cur_id unchanged.
  - SERV: INTR = 0. On an EOI write, set last <= cur_id and go to IDLE.
- Round-robin: the winner is the first set IPEND bit scanning last+1, last+2, … modulo NIRQ.
  - Reset sets last = NIRQ-1, so source 0 has top priority first.
  - last updates only on EOI, never on withdraw.
- IRQ stays level; the device clears its own request (e.g. the CPU reads the data register). The controller does not clear device state.

## Timing
- Reset (async, immediate):
  - state = IDLE, IMASK = 0, cur_id = 0, last = NIRQ-1.
  - INTR = 0; DBUS = Z.
  - DEBUG = {2'b00, 4'h0, 2'b00}.
- INTR is registered from state.
  - A request visible in IDLE at edge k gives INTR = 1 after edge k.
  - INTA sampled at edge m drops INTR after edge m.
- EOI at edge n returns to IDLE after n. The earliest new REQ is after edge n+1, so there is a minimum of one IDLE cycle.
- Reads are combinational in the cycle the read hit is asserted. Writes take effect at the next posedge.
- Simultaneous events:
  - IMASK write during IDLE selection: arbitration uses the old mask.
  - INTA in the same cycle that IPEND[cur_id] falls: INTA wins, go to SERV.
  - EOI write in IDLE or REQ: ignored.
  - INTA outside REQ: ignored.
- RESET asserted mid-REQ or mid-SERV: abandon immediately. INTR = 0 and IMASK = 0, so a stale service is never resumed.
- FLUSH = 1 during an EOI or IMASK write: the write is dropped and state is unchanged.

## Test plan
- Reset then mask: IMASK = 0, IRQ = 4'b0101 → INTR stays 0, IPEND reads 0. Write IMASK = 4'hF → INTR = 1 one cycle later, ICUR = 32'h8000_0000 (id 0).
- Round-robin: IRQ = 4'b1111, IMASK = 4'hF. Run the INTA/EOI loop four times → served IDs 0, 1, 2, 3, then 0. At least one IDLE cycle between each EOI and the next INTR.
- Withdraw: IRQ = 4'b0100 → REQ with id 2. Drop IRQ[2] before INTA → INTR falls the next cycle, state returns to IDLE, ICUR = 0. Raise IRQ[1] → id 1 is selected (last unchanged at 3).
- Simultaneous: in REQ, pulse INTA in the same cycle IRQ[cur_id] falls → state = SERV, ICUR valid. EOI written during REQ is ignored, and the state stays REQ.
- FLUSH: an EOI write in SERV with FLUSH = 1 → state stays SERV. Repeat with FLUSH = 0 → state = IDLE.
- Async reset in SERV with IMASK = 4'hF → INTR = 0 and DEBUG = 8'h00 without waiting for a clock edge; IMASK reads 0 afterwards.

Source files
------------

// File: rtl/intr_ctrl.sv
// Memory-mapped interrupt controller: masks device IRQ lines, picks one winner
// with round-robin priority and holds it through an INTA / EOI handshake.
module intr_ctrl #(
  parameter int                 BITS = 32,
  parameter logic [BITS-1:0]    BASE = 32'hF000_0800,
  parameter int                 NIRQ = 4
) (
  input  logic              CLK,
  input  logic              RESET,
  input  logic [BITS-1:0]   ABUS,
  inout  wire  [BITS-1:0]   DBUS,
  input  logic              WE,
  input  logic              FLUSH,
  input  logic [NIRQ-1:0]   IRQ,
  input  logic              INTA,
  output logic              INTR,
  output logic [7:0]        DEBUG
);

  localparam logic [BITS-1:0] ADDR_IMASK = BASE;
  localparam logic [BITS-1:0] ADDR_IPEND = BASE + BITS'(4);
  localparam logic [BITS-1:0] ADDR_ICUR  = BASE + BITS'(8);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    SERV = 2'd2
  } state_t;

  state_t            state, state_next;
  logic [3:0]        cur_id, cur_id_next;
  logic [3:0]        last, last_next;
  logic [NIRQ-1:0]   imask;
  logic [NIRQ-1:0]   ipend;
  logic [15:0]       ipend_ext;

  logic              sel_imask, sel_ipend, sel_icur;
  logic              rd_hit;
  logic              eoi;
  logic [BITS-1:0]   rdata;

  logic              win_found;
  logic [3:0]        win_id;
  logic [4:0]        scan_sum;

  // Write data above the mask width carries no meaning for this block.
  logic              unused_dbus;
  assign unused_dbus = &{1'b0, DBUS[BITS-1:NIRQ]};

  // ---------------------------------------------------------------------------
  // Bus decode
  // ---------------------------------------------------------------------------
  assign sel_imask = (ABUS == ADDR_IMASK) && !FLUSH;
  assign sel_ipend = (ABUS == ADDR_IPEND) && !FLUSH;
  assign sel_icur  = (ABUS == ADDR_ICUR)  && !FLUSH;
  assign rd_hit    = !WE && (sel_imask || sel_ipend || sel_icur);
  assign eoi       = WE && sel_icur;

  assign ipend = IRQ & imask;

  always_comb begin
    ipend_ext             = '0;
    ipend_ext[NIRQ-1:0]   = ipend;
  end

  always_comb begin
    rdata = '0;
    if (sel_imask) begin
      rdata[NIRQ-1:0] = imask;
    end else if (sel_ipend) begin
      rdata[NIRQ-1:0] = ipend;
    end else if (sel_icur && (state != IDLE)) begin
      rdata[BITS-1] = 1'b1;
      rdata[3:0]    = cur_id;
    end
  end

  assign DBUS = rd_hit ? rdata : {BITS{1'bz}};

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of block ordering.
  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      imask <= '0;
    end else if (WE && sel_imask) begin
      imask <= DBUS[NIRQ-1:0];
    end
  end

  // ---------------------------------------------------------------------------
  // Round-robin arbiter: first pending source after the last one serviced
  // ---------------------------------------------------------------------------
  always_comb begin
    win_found = 1'b0;
    win_id    = '0;
    scan_sum  = '0;
    for (int i = 1; i <= NIRQ; i++) begin
      scan_sum = {1'b0, last} + 5'(i);
      if (scan_sum >= 5'(NIRQ)) begin
        scan_sum = scan_sum - 5'(NIRQ);
      end
      if (!win_found && ipend_ext[scan_sum[3:0]]) begin
        win_found = 1'b1;
        win_id    = scan_sum[3:0];
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Service FSM
  // ---------------------------------------------------------------------------
  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      state  <= IDLE;
      cur_id <= '0;
      last   <= 4'(NIRQ - 1);
    end else begin
      state  <= state_next;
      cur_id <= cur_id_next;
      last   <= last_next;
    end
  end

  // NOTE: every output of this block gets a default first, so no path can
  // leave a variable unassigned and infer a latch.
  always_comb begin
    state_next  = state;
    cur_id_next = cur_id;
    last_next   = last;
    unique case (state)
      IDLE: begin
        if (win_found) begin
          cur_id_next = win_id;
          state_next  = REQ;
        end
      end
      REQ: begin
        // Acknowledge beats a simultaneous drop of the request.
        if (INTA) begin
          state_next = SERV;
        end else if (!ipend_ext[cur_id]) begin
          state_next = IDLE;
        end
      end
      SERV: begin
        if (eoi) begin
          last_next  = cur_id;
          state_next = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  assign INTR  = (state == REQ);
  assign DEBUG = {state, cur_id, 2'b00};

endmodule
